inst_fetch_queue: RTL

Parametrised instruction buffer between the IF and ID stages. It decouples fetch width from issue width: it accepts up to FETCH_WIDTH sequential instructions per cycle and presents up to ISSUE_WIDTH instructions per cycle, in order, to the decode/issue lanes. The issue controller pops any prefix of the presented window, which generalises the fixed two-slot inst2_taken scheme to N lanes. Flush from ctrl empties the queue in one cycle.

---
 rtl/inst_fetch_queue.sv | 92 +++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// In-order IF->ID instruction queue: up to FETCH_WIDTH pushed and ISSUE_WIDTH presented per cycle, one-cycle latency.
// push_ready is credit from the registered count only; a pop of any prefix of the presented window is accepted.
module inst_fetch_queue #(
  parameter int DEPTH       = 8,
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             push_valid,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0] push_count,
  input  logic [31:0]                      push_pc,
  input  logic [32*FETCH_WIDTH-1:0]        push_inst,
  output logic                             push_ready,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0] pop_count,
  output logic [ISSUE_WIDTH-1:0]           out_valid,
  output logic [32*ISSUE_WIDTH-1:0]        out_inst,
  output logic [32*ISSUE_WIDTH-1:0]        out_pc,
  output logic [$clog2(DEPTH+1)-1:0]       occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   inst_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] push_eff, pop_eff;
  logic [CW-1:0] push_req, pop_req;
  logic          accept;

  assign push_ready = (CW'(DEPTH) - count_q) >= CW'(FETCH_WIDTH);
  assign occupancy  = count_q;

  always_comb begin
    accept   = push_valid & push_ready & ~flush;
    push_req = CW'(push_count);
    if (push_req > CW'(FETCH_WIDTH)) push_req = CW'(FETCH_WIDTH);
    push_eff = accept ? push_req : '0;
    pop_req  = CW'(pop_count);
    if (pop_req > CW'(ISSUE_WIDTH)) pop_req = CW'(ISSUE_WIDTH);
    if (pop_req > count_q) pop_req = count_q;
    pop_eff  = flush ? '0 : pop_req;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(pop_eff);
      tail_d  = tail_q + PW'(push_eff);
      count_d = count_q + push_eff - pop_eff;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      // Pushes only ever land in free slots, so the presented window is untouched.
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (CW'(k) < push_eff) begin
          pc_q[tail_q + PW'(k)]   <= push_pc + 32'(4 * k);
          inst_q[tail_q + PW'(k)] <= push_inst[32*k +: 32];
        end
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (CW'(k) < count_q) begin
        out_valid[k]       = 1'b1;
        out_inst[32*k +: 32] = inst_q[head_q + PW'(k)];
        out_pc[32*k +: 32]   = pc_q[head_q + PW'(k)];
      end
    end
  end
endmodule
